// File: rtl/phase_seq_pkg.sv
// -----------------------------------------------------------------------------
// phase_seq_pkg
//   Shared types and defaults for the phase sequencer controller.
//   - state_e    : controller state encoding (IDLE, RUN, PAUSE, DONE)
//   - NPHASE_DEF : default number of phases
//   - IDX_W_DEF  : binary index width for the default phase count
// -----------------------------------------------------------------------------
package phase_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int NPHASE_DEF = 6;
    localparam int IDX_W_DEF  = $clog2(NPHASE_DEF);

endpackage

// File: rtl/phase_seq_ctrl_dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
//   Loadable down-counter that measures how long the current phase has left.
//   Loading value D leaves D-1 further cycles after the load edge, so a phase
//   is visible for exactly max(D,1) counting cycles. A zero load is treated
//   as one.
// Ports
//   clk        in  clock, rising edge
//   rst_n      in  asynchronous active-low reset (counter -> 0)
//   load_i     in  load a fresh dwell (takes precedence over counting)
//   load_val_i in  dwell length in cycles
//   hold_i     in  freeze the count
//   expire_o   out current cycle is the last cycle of the dwell
// -----------------------------------------------------------------------------
module dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_val_i,
    input  logic               hold_i,
    output logic               expire_o
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (load_val_i == '0) ? '0 : load_val_i - 1'b1;
        end else if (!hold_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/phase_seq_ctrl.sv
// -----------------------------------------------------------------------------
// phase_seq_ctrl
//   Run-time controller for an NPHASE one-hot phase sequencer: start / stop /
//   pause / single-step, programmable dwell per phase, loop counting and a
//   one-cycle completion pulse. All outputs are registered.
//
//   Optional feature: define SEQ_REVERSE_EN to add the 'dir' input. dir is
//   sampled at start; dir=1 walks NPHASE-1 down to 0 and the 0 -> NPHASE-1
//   wrap completes a loop. Without the macro the walk is forward only.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a sequence (honoured only in IDLE)
//   stop       in   abort to IDLE, highest priority
//   pause      in   level: hold current phase while high
//   step       in   pulse: advance one phase while paused
//   dir        in   (SEQ_REVERSE_EN only) 1 = reverse walk, sampled at start
//   dwell      in   cycles per phase, sampled at start; 0 behaves as 1
//   loops      in   loops to run, sampled at start; 0 = run forever
//   phase_oh   out  one-hot active phase, zero when not running
//   phase_idx  out  binary index of active phase, zero when not running
//   busy       out  high whenever not IDLE
//   done       out  one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module phase_seq_ctrl
    import phase_seq_pkg::*;
#(
    parameter  int NPHASE  = NPHASE_DEF,
    parameter  int DWELL_W = 16,
    parameter  int LOOP_W  = 8,
    localparam int IDX_W   = $clog2(NPHASE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               step,
`ifdef SEQ_REVERSE_EN
    input  logic               dir,
`endif
    input  logic [DWELL_W-1:0] dwell,
    input  logic [LOOP_W-1:0]  loops,
    output logic [NPHASE-1:0]  phase_oh,
    output logic [IDX_W-1:0]   phase_idx,
    output logic               busy,
    output logic               done
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NPHASE - 1);

    state_e             state_q, state_d;
    logic [NPHASE-1:0]  phase_oh_q, phase_oh_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_nxt;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [LOOP_W-1:0]  loop_cnt_q, loop_cnt_d, loop_inc;
    logic [DWELL_W-1:0] dwell_q;
    logic [LOOP_W-1:0]  loops_q;

    logic               rev_start, rev_q;
    logic               go_start, adv, wrap, last_loop;
    logic               tmr_expire, tmr_load, tmr_hold;
    logic [DWELL_W-1:0] tmr_val;

`ifdef SEQ_REVERSE_EN
    logic dir_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= 1'b0;
        end else if (go_start) begin
            dir_q <= dir;
        end
    end

    assign rev_start = dir;
    assign rev_q     = dir_q;
`else
    assign rev_start = 1'b0;
    assign rev_q     = 1'b0;
`endif

    // Phase walk arithmetic: the wrap edge is the one that completes a loop,
    // and a wrap that reaches the programmed loop count ends the sequence.
    assign wrap      = rev_q ? (idx_q == '0) : (idx_q == IDX_LAST);
    assign loop_inc  = loop_cnt_q + 1'b1;
    assign last_loop = wrap && (loops_q != '0) && (loop_inc == loops_q);

    always_comb begin
        if (rev_q) begin
            idx_nxt = wrap ? IDX_LAST : idx_q - 1'b1;
        end else begin
            idx_nxt = wrap ? '0 : idx_q + 1'b1;
        end
    end

    // The start edge loads straight from the dwell input because dwell_q is
    // only being captured on that same edge.
    assign tmr_load = go_start | adv;
    assign tmr_val  = go_start ? dwell : dwell_q;
    assign tmr_hold = (state_q != ST_RUN);

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .hold_i     (tmr_hold),
        .expire_o   (tmr_expire)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A RUN cycle always counts toward the dwell, even the
    // cycle in which pause is first seen; the freeze starts on the next cycle.
    always_comb begin
        state_d  = state_q;
        go_start = 1'b0;
        adv      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!stop && start) begin
                    state_d  = ST_RUN;
                    go_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    adv = tmr_expire;
                    if (tmr_expire && last_loop) begin
                        state_d = ST_DONE;
                    end else if (pause) begin
                        state_d = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end else if (step) begin
                    adv = 1'b1;
                    if (last_loop) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output / datapath next values, all derived from the upcoming state so
    // the registered outputs line up with it.
    always_comb begin
        idx_d      = idx_q;
        loop_cnt_d = loop_cnt_q;
        if (go_start) begin
            idx_d      = rev_start ? IDX_LAST : '0;
            loop_cnt_d = '0;
        end else if (adv) begin
            idx_d = idx_nxt;
            if (wrap) begin
                loop_cnt_d = loop_inc;
            end
        end
        if ((state_d == ST_IDLE) || (state_d == ST_DONE)) begin
            idx_d = '0;
        end

        phase_oh_d = '0;
        if ((state_d == ST_RUN) || (state_d == ST_PAUSE)) begin
            phase_oh_d = {{(NPHASE-1){1'b0}}, 1'b1} << idx_d;
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            phase_oh_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            loop_cnt_q <= '0;
            dwell_q    <= '0;
            loops_q    <= '0;
        end else begin
            idx_q      <= idx_d;
            phase_oh_q <= phase_oh_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            loop_cnt_q <= loop_cnt_d;
            if (go_start) begin
                dwell_q <= dwell;
                loops_q <= loops;
            end
        end
    end

    assign phase_oh  = phase_oh_q;
    assign phase_idx = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
